icache_refill_ctrl: RTL and testbench

- Controller that sequences instruction-cache line refills for the fetch stage.
- On a lookup miss at PCF it holds the PC register and sends bubbles to decode.
- It issues one burst request to main memory, writes the returned words into the cache data array, then marks the line valid.
- Sits beside the fetch stage. Its stall/flush outputs drive the PC register hold, the F/D pipeline register clear, and the fetch pipeline-register enable path.

---
 rtl/icache_refill_ctrl_pkg.sv | 15 +
 rtl/icache_refill_ctrl_if.sv | 27 ++
 rtl/icache_refill_ctrl_sat_counter.sv | 21 ++
 rtl/icache_refill_ctrl.sv | 113 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the fetch-side refill controller.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, REQ, FILL} refill_state_t;

    localparam int          WORDS_PER_LINE_DEFAULT = 4;
    localparam int          LINE_OFFSET_BITS       = $clog2(WORDS_PER_LINE_DEFAULT * 4);
    localparam logic [31:0] NOP_INSTR              = 32'h00000013;

    // Byte-offset bits inside a line of 'words' 32-bit words.
    function automatic int line_offset_bits(input int words);
        return $clog2(words * 4);
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Burst-read bus between the refill controller and main memory.
interface icache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill sequencer: miss -> burst request -> word fill -> valid.
//   state | meaning
//   IDLE  | lookup each cycle; a clean miss latches the line base and starts a refill
//   REQ   | burst request held until memory accepts
//   FILL  | write each returned beat; last beat pulses fill_done_o
module icache_refill_ctrl
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PCF,
    input  logic                  hit_i,
    input  logic                  redirect_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  fill_we_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  fill_done_o,
    output logic                  stall_f_o,
    output logic                  flush_d_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o
);
    localparam int                    OFF      = line_offset_bits(WORDS_PER_LINE);
    localparam int                    CW       = $clog2(WORDS_PER_LINE);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = (ADDR_WIDTH'(1) << OFF) - 1'b1;
    localparam logic [CW-1:0]         LAST_CNT = CW'(WORDS_PER_LINE - 1);

    refill_state_t         state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  abort_q, abort_d;
    logic                  abort_unused;

    logic miss_start;
    logic last_beat;

    // Outputs are forced quiet while reset is asserted.
    assign miss_start = ~rst & (state_q == IDLE) & ~hit_i & ~redirect_i;
    assign last_beat  = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (miss_start) begin
                    base_d  = PCF & ~OFF_MASK;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_i) abort_d = 1'b1;
                if (mem_ready_i) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (redirect_i) abort_d = 1'b1;
                if (mem_rvalid_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            abort_q <= abort_d;
        end
    end

    // The redirect-during-refill flag is kept for debug probing only.
    assign abort_unused = abort_q;

    assign mem_req_o   = ~rst & (state_q == REQ);
    assign mem_addr_o  = base_q;
    assign fill_we_o   = ~rst & (state_q == FILL) & mem_rvalid_i;
    assign fill_addr_o = fill_we_o ? (base_q + ADDR_WIDTH'({cnt_q, 2'b00})) : '0;
    assign fill_data_o = fill_we_o ? mem_rdata_i : '0;
    assign fill_done_o = fill_we_o & last_beat;
    assign stall_f_o   = miss_start | (~rst & (state_q != IDLE));
    assign flush_d_o   = stall_f_o;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (miss_start),
        .count_o (miss_count_o)
    );
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl; a second narrow-counter instance covers saturation.
module tb_icache_refill_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        hit_i;
    logic        redirect_i;
    logic        fill_we_o;
    logic [31:0] fill_addr_o;
    logic [31:0] fill_data_o;
    logic        fill_done_o;
    logic        stall_f_o;
    logic        flush_d_o;
    logic [15:0] miss_count_o;

    icache_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .PCF          (PCF),
        .hit_i        (hit_i),
        .redirect_i   (redirect_i),
        .mem_req_o    (mif.mem_req),
        .mem_addr_o   (mif.mem_addr),
        .mem_ready_i  (mif.mem_ready),
        .mem_rvalid_i (mif.mem_rvalid),
        .mem_rdata_i  (mif.mem_rdata),
        .fill_we_o    (fill_we_o),
        .fill_addr_o  (fill_addr_o),
        .fill_data_o  (fill_data_o),
        .fill_done_o  (fill_done_o),
        .stall_f_o    (stall_f_o),
        .flush_d_o    (flush_d_o),
        .miss_count_o (miss_count_o)
    );

    // Saturation instance: 2-word lines, 2-bit counter, memory always ready/valid.
    logic        s_hit = 1'b1;
    logic        s_req, s_we, s_done, s_stall, s_flush;
    logic [31:0] s_maddr, s_faddr, s_fdata;
    logic [1:0]  s_count;
    int          s_ndone = 0;

    icache_refill_ctrl #(.WORDS_PER_LINE(2), .CNT_WIDTH(2)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .PCF          (32'h0000_4000),
        .hit_i        (s_hit),
        .redirect_i   (1'b0),
        .mem_req_o    (s_req),
        .mem_addr_o   (s_maddr),
        .mem_ready_i  (1'b1),
        .mem_rvalid_i (1'b1),
        .mem_rdata_i  (32'h5A5A_5A5A),
        .fill_we_o    (s_we),
        .fill_addr_o  (s_faddr),
        .fill_data_o  (s_fdata),
        .fill_done_o  (s_done),
        .stall_f_o    (s_stall),
        .flush_d_o    (s_flush),
        .miss_count_o (s_count)
    );

    always @(posedge clk) if (s_done) s_ndone <= s_ndone + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One refill from the miss cycle through the done beat; pat is LSB-first rvalid pattern.
    task automatic refill(input logic [31:0] pc, input logic [31:0] line, input int wait_n,
                          input logic [15:0] pat, input int plen, input logic [31:0] dbase,
                          input logic [31:0] expcnt, input int redir_beat);
        int beat;
        PCF = pc; hit_i = 1'b0; redirect_i = 1'b0;
        mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0;
        #1;
        chk("miss_stall", {31'd0, stall_f_o}, 32'd1);
        chk("miss_flush", {31'd0, flush_d_o}, 32'd1);
        chk("miss_req", {31'd0, mif.mem_req}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < wait_n; i++) begin
            #1;
            chk("req_wait", {31'd0, mif.mem_req}, 32'd1);
            chk("req_addr", mif.mem_addr, line);
            chk("req_stall", {31'd0, stall_f_o}, 32'd1);
            @(negedge clk);
        end
        mif.mem_ready = 1'b1;
        #1;
        chk("req_acc", {31'd0, mif.mem_req}, 32'd1);
        chk("req_acc_addr", mif.mem_addr, line);
        chk("miss_count", {16'd0, miss_count_o}, expcnt);
        @(negedge clk);
        mif.mem_ready = 1'b0;
        beat = 0;
        for (int i = 0; i < plen && beat < 4; i++) begin
            mif.mem_rvalid = pat[i];
            mif.mem_rdata  = dbase + beat;
            redirect_i     = pat[i] && (beat == redir_beat);
            #1;
            chk("fill_we", {31'd0, fill_we_o}, {31'd0, pat[i]});
            chk("fill_stall", {31'd0, stall_f_o}, 32'd1);
            chk("fill_req", {31'd0, mif.mem_req}, 32'd0);
            if (pat[i]) begin
                chk("fill_addr", fill_addr_o, line + beat * 4);
                chk("fill_data", fill_data_o, dbase + beat);
                chk("fill_done", {31'd0, fill_done_o}, (beat == 3) ? 32'd1 : 32'd0);
                beat++;
            end else begin
                chk("gap_done", {31'd0, fill_done_o}, 32'd0);
            end
            @(negedge clk);
        end
        mif.mem_rvalid = 1'b0;
        redirect_i = 1'b0;
        chk("beats_seen", beat, 32'd4);
    endtask

    task automatic idle_hit(input logic [31:0] expcnt);
        hit_i = 1'b1; redirect_i = 1'b0;
        #1;
        chk("idle_stall", {31'd0, stall_f_o}, 32'd0);
        chk("idle_req", {31'd0, mif.mem_req}, 32'd0);
        chk("idle_done", {31'd0, fill_done_o}, 32'd0);
        chk("idle_count", {16'd0, miss_count_o}, expcnt);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; PCF = 32'h0; hit_i = 1'b1; redirect_i = 1'b0;
        mif.mem_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            #1;
            chk("rst_stall", {31'd0, stall_f_o}, 32'd0);
            chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
            chk("rst_count", {16'd0, miss_count_o}, 32'd0);
            @(negedge clk);
        end

        refill(32'h0000_1018, 32'h0000_1010, 2, 16'b1111, 4, 32'h0000_00A0, 32'd1, -1);
        idle_hit(32'd1);

        refill(32'h0000_1018, 32'h0000_1010, 0, 16'b1011001, 7, 32'h0000_00B0, 32'd2, -1);
        idle_hit(32'd2);

        // Wrong-path miss in IDLE must not start a refill.
        PCF = 32'h0000_5000; hit_i = 1'b0; redirect_i = 1'b1;
        #1;
        chk("redir_idle_stall", {31'd0, stall_f_o}, 32'd0);
        chk("redir_idle_req", {31'd0, mif.mem_req}, 32'd0);
        @(negedge clk);
        hit_i = 1'b1; redirect_i = 1'b0;
        #1;
        chk("redir_idle_req2", {31'd0, mif.mem_req}, 32'd0);
        chk("redir_idle_count", {16'd0, miss_count_o}, 32'd2);
        @(negedge clk);

        // Redirect on beat 2, then the redirected PC misses in the single IDLE cycle.
        refill(32'h0000_3008, 32'h0000_3000, 1, 16'b1111, 4, 32'h0000_00C0, 32'd3, 1);
        refill(32'h0000_2004, 32'h0000_2000, 0, 16'b1111, 4, 32'h0000_00D0, 32'd4, -1);
        idle_hit(32'd4);

        // Reset mid-burst: two beats, then reset with stale beats still arriving.
        PCF = 32'h0000_1018; hit_i = 1'b0;
        @(negedge clk);
        mif.mem_ready = 1'b1;
        @(negedge clk);
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'hE0 + i;
            #1;
            chk("pre_rst_we", {31'd0, fill_we_o}, 32'd1);
            @(negedge clk);
        end
        rst = 1'b1; hit_i = 1'b1;
        #1;
        chk("in_rst_we", {31'd0, fill_we_o}, 32'd0);
        chk("in_rst_stall", {31'd0, stall_f_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("post_rst_we", {31'd0, fill_we_o}, 32'd0);
            chk("post_rst_done", {31'd0, fill_done_o}, 32'd0);
            chk("post_rst_stall", {31'd0, stall_f_o}, 32'd0);
            chk("post_rst_req", {31'd0, mif.mem_req}, 32'd0);
            chk("post_rst_count", {16'd0, miss_count_o}, 32'd0);
            chk("post_rst_addr", mif.mem_addr, 32'd0);
            @(negedge clk);
        end
        mif.mem_rvalid = 1'b0;

        // Continuous misses on the 2-bit instance: count must stick at 3.
        chk("sat_start", {30'd0, s_count}, 32'd0);
        s_hit = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("sat_count", {30'd0, s_count}, 32'd3);
        chk("sat_refills_ge4", (s_ndone >= 4) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
